// File: rtl/ovl_even_parity_encoder.sv
// Even-parity encoder: appends a parity bit per beat and optionally closes each frame with an LRC trailer.
// Accepted beats are visible one edge later; in_ready depends only on registered state, so out_ready stalls back up through the 2-entry buffer.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  // A push into a full FIFO is dropped even when a pop happens in the same cycle.
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end
endmodule

module ovl_even_parity_encoder #(
  parameter int width        = 8,
  parameter bit frame_parity = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  input  logic             inject_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width:0]   out_data,
  output logic             out_last,
  output logic             out_trailer,
  output logic [15:0]      beat_count
);
  typedef enum logic [1:0] {IDLE, FRAME, TRAILER} state_t;

  typedef struct packed {
    logic           last;
    logic           trailer;
    logic [width:0] dat;
  } beat_t;

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] acc;
  logic             in_acc;
  logic             trl_push;
  logic             push;
  beat_t            push_beat;
  beat_t            head;
  logic             pop;
  logic             full;
  logic             empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FRAME: begin
        if (in_acc) begin
          if (!in_last)          state_nxt = FRAME;
          else if (frame_parity) state_nxt = TRAILER;
          else                   state_nxt = IDLE;
        end
      end
      TRAILER: if (!full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && enable && !full && (state != TRAILER);
    in_acc    = in_valid && in_ready;
    trl_push  = (state == TRAILER) && !full;
    push      = in_acc || trl_push;
    push_beat = '0;
    if (trl_push) begin
      // Trailer parity is never injected so the LRC itself stays trustworthy.
      push_beat.last    = 1'b1;
      push_beat.trailer = 1'b1;
      push_beat.dat     = {^acc, acc};
    end else begin
      push_beat.last = !frame_parity && in_last;
      push_beat.dat  = {(^in_data) ^ inject_err, in_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      acc <= '0;
    else if (trl_push)              acc <= '0;
    else if (in_acc && frame_parity) acc <= acc ^ in_data;
  end

  sync_fifo #(.W($bits(beat_t)), .DEPTH(2)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_beat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign {out_last, out_trailer, out_data} = head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    beat_count <= '0;
    else if (pop) beat_count <= beat_count + 16'd1;
  end
endmodule

// File: tb/tb_ovl_even_parity_encoder.sv
// Bench: instance a has no trailer, instance b emits LRC trailers; b also runs a randomized queue-model comparison.
module tb_ovl_even_parity_encoder;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       last;
    logic       trl;
    logic [8:0] dat;
  } beat_t;

  int errs   = 0;
  int checks = 0;

  logic       a_en, a_iv, a_irdy, a_il, a_ie, a_ov, a_or, a_ol, a_ot;
  logic [7:0] a_id;
  logic [8:0] a_od;
  logic [15:0] a_bc;
  logic       b_en, b_iv, b_irdy, b_il, b_ie, b_ov, b_or, b_ol, b_ot;
  logic [7:0] b_id;
  logic [8:0] b_od;
  logic [15:0] b_bc;

  ovl_even_parity_encoder #(.width(8), .frame_parity(1'b0)) u_a (
    .clock(clock), .reset(reset), .enable(a_en), .in_valid(a_iv), .in_ready(a_irdy),
    .in_data(a_id), .in_last(a_il), .inject_err(a_ie), .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .out_last(a_ol), .out_trailer(a_ot), .beat_count(a_bc)
  );

  ovl_even_parity_encoder #(.width(8), .frame_parity(1'b1)) u_b (
    .clock(clock), .reset(reset), .enable(b_en), .in_valid(b_iv), .in_ready(b_irdy),
    .in_data(b_id), .in_last(b_il), .inject_err(b_ie), .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .out_last(b_ol), .out_trailer(b_ot), .beat_count(b_bc)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  beat_t b_seen[$];
  beat_t b_exp[$];

  always @(negedge clock)
    if (!reset && b_ov && b_or) b_seen.push_back({b_ol, b_ot, b_od});

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b0; b_or = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
    b_seen.delete();
    b_exp.delete();
  endtask

  task automatic a_beat(input string tag, input logic [7:0] d, input logic l, input logic ie,
                        input logic [8:0] exp_od, input logic exp_ol);
    a_or = 1'b0; a_iv = 1'b1; a_id = d; a_il = l; a_ie = ie;
    step();
    a_iv = 1'b0; a_ie = 1'b0;
    chk_val({tag, "_valid"}, a_ov, 1);
    chk_val({tag, "_data"}, a_od, exp_od);
    chk_val({tag, "_last"}, a_ol, exp_ol);
    chk_val({tag, "_trailer"}, a_ot, 0);
    a_or = 1'b1;
    step();
    a_or = 1'b0;
    chk_val({tag, "_drained"}, a_ov, 0);
  endtask

  task automatic b_push(input logic [7:0] d, input logic l);
    logic took;
    took = 1'b0;
    b_iv = 1'b1; b_id = d; b_il = l; b_ie = 1'b0;
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge clock);
      took = b_irdy;
      step();
    end
    b_iv = 1'b0;
    chk_val("b_push_accept", took, 1);
  endtask

  task automatic b_compare(input string tag);
    chk_val({tag, "_count"}, b_seen.size(), b_exp.size());
    foreach (b_exp[i])
      if (i < b_seen.size()) chk_val($sformatf("%s_beat%0d", tag, i), b_seen[i], b_exp[i]);
  endtask

  beat_t       mq[$];
  logic [7:0]  macc;
  logic        mtp;
  logic [15:0] mbc;
  logic        exp_rdy;
  logic        do_trl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    a_en = 1'b1; a_iv = 1'b0; a_id = '0; a_il = 1'b0; a_ie = 1'b0; a_or = 1'b0;
    b_en = 1'b1; b_iv = 1'b0; b_id = '0; b_il = 1'b0; b_ie = 1'b0; b_or = 1'b0;
    #12;
    chk_val("rst_a_in_ready", a_irdy, 0);
    chk_val("rst_a_out_valid", a_ov, 0);
    chk_val("rst_a_out_data", a_od, 0);
    chk_val("rst_a_out_flags", {a_ol, a_ot}, 0);
    chk_val("rst_a_beat_count", a_bc, 0);
    chk_val("rst_b_in_ready", b_irdy, 0);
    chk_val("rst_b_out_valid", b_ov, 0);
    chk_val("rst_b_out_data", b_od, 0);
    chk_val("rst_b_out_flags", {b_ol, b_ot}, 0);
    chk_val("rst_b_beat_count", b_bc, 0);
    reset = 1'b0;
    #1;
    chk_val("post_rst_a_in_ready", a_irdy, 1);
    chk_val("post_rst_b_in_ready", b_irdy, 1);
    step();

    // Without trailers: parity, last forwarding and error injection.
    a_beat("a_03_last", 8'h03, 1'b1, 1'b0, 9'h003, 1'b1);
    chk_val("a_count_after_one", a_bc, 1);
    a_beat("a_07", 8'h07, 1'b0, 1'b0, 9'h107, 1'b0);
    a_beat("a_07_inject", 8'h07, 1'b0, 1'b1, 9'h007, 1'b0);

    // Three-beat frame followed by its LRC trailer.
    b_or = 1'b1;
    b_push(8'h01, 1'b0);
    b_push(8'h02, 1'b0);
    b_push(8'h04, 1'b1);
    repeat (6) step();
    b_exp = '{{1'b0, 1'b0, 9'h101}, {1'b0, 1'b0, 9'h102}, {1'b0, 1'b0, 9'h104}, {1'b1, 1'b1, 9'h107}};
    b_compare("frame3");

    // Backpressure: buffer fills after two beats, head holds, no bypass on release.
    do_reset();
    b_push(8'hA5, 1'b0);
    b_push(8'h3C, 1'b0);
    b_iv = 1'b1; b_id = 8'hF0; b_il = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk_val("bp_in_ready_low", b_irdy, 0);
      chk_val("bp_head_stable", {b_ov, b_od}, {1'b1, 9'h0A5});
      step();
    end
    b_or = 1'b1;
    @(negedge clock);
    chk_val("bp_no_bypass", b_irdy, 0);
    step();
    b_push(8'hF0, 1'b1);
    repeat (8) step();
    b_exp = '{{1'b0, 1'b0, 9'h0A5}, {1'b0, 1'b0, 9'h03C}, {1'b0, 1'b0, 9'h0F0}, {1'b1, 1'b1, 9'h069}};
    b_compare("backpressure");
    chk_val("bp_beat_count", b_bc, 4);

    // Reset mid-frame discards the frame and its accumulator.
    do_reset();
    b_push(8'h55, 1'b0);
    b_push(8'h66, 1'b0);
    chk_val("mid_rst_pre_valid", b_ov, 1);
    reset = 1'b1;
    #1;
    chk_val("mid_rst_out_valid", b_ov, 0);
    chk_val("mid_rst_in_ready", b_irdy, 0);
    #2;
    reset = 1'b0;
    step();
    b_seen.delete();
    b_or = 1'b1;
    b_push(8'h11, 1'b1);
    repeat (5) step();
    b_exp = '{{1'b0, 1'b0, 9'h011}, {1'b1, 1'b1, 9'h011}};
    b_compare("after_rst");

    // Randomized traffic against a queue model of the buffer contents.
    do_reset();
    mq.delete(); macc = '0; mtp = 1'b0; mbc = '0;
    for (int c = 0; c < 3000; c++) begin
      b_en = ($urandom_range(7) != 0);
      b_iv = 1'($urandom_range(1));
      b_id = 8'($urandom_range(255));
      b_il = ($urandom_range(3) == 0);
      b_ie = ($urandom_range(7) == 0);
      b_or = ($urandom_range(3) != 0);
      @(negedge clock);
      exp_rdy = b_en && (mq.size() < 2) && !mtp;
      chk_val("rnd_in_ready", b_irdy, exp_rdy);
      chk_val("rnd_out_valid", b_ov, mq.size() != 0);
      if (mq.size() != 0) chk_val("rnd_out_beat", {b_ol, b_ot, b_od}, mq[0]);
      chk_val("rnd_beat_count", b_bc, mbc);
      do_trl = mtp && (mq.size() < 2);
      if (mq.size() != 0 && b_or) begin
        void'(mq.pop_front());
        mbc++;
      end
      if (b_iv && exp_rdy) begin
        mq.push_back({1'b0, 1'b0, (^b_id) ^ b_ie, b_id});
        macc ^= b_id;
        if (b_il) mtp = 1'b1;
      end else if (do_trl) begin
        mq.push_back({1'b1, 1'b1, ^macc, macc});
        macc = '0;
        mtp = 1'b0;
      end
      step();
    end
    b_en = 1'b1; b_iv = 1'b0; b_ie = 1'b0;

    // beat_count wrap: continuous flow gives one transfer per edge after the first.
    do_reset();
    a_iv = 1'b1; a_il = 1'b1; a_ie = 1'b0; a_id = 8'($urandom); a_or = 1'b1;
    repeat (65536) step();
    chk_val("wrap_at_ffff", a_bc, 16'hFFFF);
    step();
    chk_val("wrap_to_zero", a_bc, 16'h0000);
    a_iv = 1'b0; a_or = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
